// File: rtl/mpu_i2c_responder.sv
// mpu_i2c_responder: I2C target emulating the MPU-6050 register map.
// Config macro: MPU_I2C_AUTOINC_EN (defined = pointer advances per data byte).
// Ports: slow_clk, ResetN (sync, active-low), SCL_in/SDA_in (async bus),
//   SDA_oe (1 = pull low), SensorData (96b, AXH first), PwrMgmt (0x6B),
//   WrStrobe/WrAddr (write report), BusBusy (START..STOP).
module mpu_i2c_responder #(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter logic [7:0] PWR_RST_VAL  = 8'h40
) (
  input  logic        slow_clk,
  input  logic        ResetN,
  input  logic        SCL_in,
  input  logic        SDA_in,
  output logic        SDA_oe,
  input  logic [95:0] SensorData,
  output logic [7:0]  PwrMgmt,
  output logic        WrStrobe,
  output logic [7:0]  WrAddr,
  output logic        BusBusy
);

`ifdef MPU_I2C_AUTOINC_EN
  localparam logic [7:0] PTR_STEP = 8'd1;
`else
  localparam logic [7:0] PTR_STEP = 8'd0;
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ADDR_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  state_t      state;
  logic [2:0]  scl_q;
  logic [2:0]  sda_q;
  logic        scl;
  logic        sda;
  logic        scl_rise;
  logic        scl_fall;
  logic        start;
  logic        stop;
  logic [3:0]  bit_cnt;
  logic [7:0]  sh;
  logic [7:0]  in_byte;
  logic [7:0]  rd_sh;
  logic [7:0]  rd_byte;
  logic [7:0]  ptr;
  logic [95:0] snap;
  logic        rw;
  logic        ack_clk;
  logic [7:0]  snap_b [0:11];
  logic [7:0]  acc_ofs;
  logic [7:0]  gyr_ofs;

  // [1] is the synchronised level, [2] its one-cycle history
  assign scl      = scl_q[1];
  assign sda      = sda_q[1];
  assign scl_rise = scl & ~scl_q[2];
  assign scl_fall = ~scl & scl_q[2];
  assign start    = scl & scl_q[2] & sda_q[2] & ~sda;
  assign stop     = scl & scl_q[2] & ~sda_q[2] & sda;
  assign in_byte  = {sh[6:0], sda};
  assign acc_ofs  = ptr - 8'h3B;
  assign gyr_ofs  = ptr - 8'h3D;

  always_comb begin
    for (int i = 0; i < 12; i++) begin
      snap_b[i] = snap[95-8*i -: 8];
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    if (ptr >= 8'h3B && ptr <= 8'h40) begin
      rd_byte = snap_b[acc_ofs[3:0]];
    end else if (ptr >= 8'h43 && ptr <= 8'h48) begin
      rd_byte = snap_b[gyr_ofs[3:0]];
    end else if (ptr == 8'h6B) begin
      rd_byte = PwrMgmt;
    end else if (ptr == 8'h75) begin
      rd_byte = WHO_AM_I_VAL;
    end
  end

  always_ff @(posedge slow_clk) begin
    if (!ResetN) begin
      state    <= ST_IDLE;
      scl_q    <= 3'b111;
      sda_q    <= 3'b111;
      SDA_oe   <= 1'b0;
      PwrMgmt  <= PWR_RST_VAL;
      WrStrobe <= 1'b0;
      WrAddr   <= 8'h00;
      BusBusy  <= 1'b0;
      ptr      <= 8'h00;
      snap     <= '0;
      bit_cnt  <= 4'd0;
      sh       <= 8'h00;
      rd_sh    <= 8'h00;
      rw       <= 1'b0;
      ack_clk  <= 1'b0;
    end else begin
      scl_q    <= {scl_q[1:0], SCL_in};
      sda_q    <= {sda_q[1:0], SDA_in};
      WrStrobe <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        SDA_oe  <= 1'b0;
        BusBusy <= 1'b0;
      end else if (start) begin
        state   <= ST_DEV_ADDR;
        bit_cnt <= 4'd0;
        BusBusy <= 1'b1;
      end else if (scl_rise) begin
        unique case (state)
          ST_DEV_ADDR: begin
            sh      <= in_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (in_byte[7:1] == DEV_ADDR) begin
                state   <= ST_ADDR_ACK;
                rw      <= in_byte[0];
                ack_clk <= 1'b0;
                // freeze sensor data for a coherent burst
                if (in_byte[0]) snap <= SensorData;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_REG_ADDR: begin
            sh      <= in_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ptr     <= in_byte;
              state   <= ST_REG_ACK;
              ack_clk <= 1'b0;
            end
          end
          ST_WR_DATA: begin
            sh      <= in_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              WrStrobe <= 1'b1;
              WrAddr   <= ptr;
              if (ptr == 8'h6B) PwrMgmt <= in_byte;
              ptr     <= ptr + PTR_STEP;
              state   <= ST_WR_ACK;
              ack_clk <= 1'b0;
            end
          end
          ST_RD_DATA: begin
            bit_cnt <= bit_cnt + 4'd1;
          end
          ST_RD_ACK: begin
            ptr <= ptr + PTR_STEP;
            if (sda) begin
              state <= ST_IGNORE;
            end else begin
              ack_clk <= 1'b1;
            end
          end
          ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: begin
            ack_clk <= 1'b1;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        unique case (state)
          ST_DEV_ADDR: begin
            SDA_oe <= 1'b0;
          end
          ST_ADDR_ACK: begin
            if (!ack_clk) begin
              SDA_oe <= 1'b1;
            end else begin
              bit_cnt <= 4'd0;
              if (rw) begin
                rd_sh  <= rd_byte;
                SDA_oe <= ~rd_byte[7];
                state  <= ST_RD_DATA;
              end else begin
                SDA_oe <= 1'b0;
                state  <= ST_REG_ADDR;
              end
            end
          end
          ST_REG_ACK, ST_WR_ACK: begin
            if (!ack_clk) begin
              SDA_oe <= 1'b1;
            end else begin
              SDA_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (bit_cnt == 4'd8) begin
              SDA_oe  <= 1'b0;
              ack_clk <= 1'b0;
              state   <= ST_RD_ACK;
            end else begin
              rd_sh  <= {rd_sh[6:0], 1'b0};
              SDA_oe <= ~rd_sh[6];
            end
          end
          ST_RD_ACK: begin
            if (ack_clk) begin
              rd_sh   <= rd_byte;
              SDA_oe  <= ~rd_byte[7];
              bit_cnt <= 4'd0;
              state   <= ST_RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu_i2c_responder.sv
// tb_mpu_i2c_responder: vector table of I2C transactions plus
// hand sequences for snapshot coherence and mid-transfer reset.
module tb_mpu_i2c_responder;

  localparam time Q = 60ns;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  logic        sda_bus;
  logic        SDA_oe;
  logic [95:0] SensorData = '0;
  logic [7:0]  PwrMgmt;
  logic        WrStrobe;
  logic [7:0]  WrAddr;
  logic        BusBusy;

  int n_vec = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  int oe_cnt = 0;

  assign sda_bus = ~(m_low | SDA_oe);

  always #5ns clk = ~clk;

  always @(posedge clk) begin
    strobe_cnt <= strobe_cnt + int'(WrStrobe);
    oe_cnt     <= oe_cnt + int'(SDA_oe);
  end

  mpu_i2c_responder dut (
    .slow_clk   (clk),
    .ResetN     (rst_n),
    .SCL_in     (scl),
    .SDA_in     (sda_bus),
    .SDA_oe     (SDA_oe),
    .SensorData (SensorData),
    .PwrMgmt    (PwrMgmt),
    .WrStrobe   (WrStrobe),
    .WrAddr     (WrAddr),
    .BusBusy    (BusBusy)
  );

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic i2c_start();
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; #Q;
      scl = 1'b1;    #(2*Q);
      scl = 1'b0;    #Q;
    end
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    ack = ~sda_bus;
    #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    m_low = 1'b0;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #Q;
      scl = 1'b1; #Q;
      b = {b[6:0], sda_bus};
      #Q;
      scl = 1'b0; #Q;
    end
    m_low = ~nack; #Q;
    scl = 1'b1;    #(2*Q);
    scl = 1'b0;    #Q;
    m_low = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  dev;
    logic        rd;
    logic [7:0]  reg_a;
    logic [7:0]  wdata;
    logic [95:0] sensor;
    int          nrd;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
    logic        exp_ack;
    logic [7:0]  exp_pwr;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

`ifdef MPU_I2C_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  initial begin
    logic       ack;
    logic [7:0] d0;
    logic [7:0] d1;
    int         s0;
    int         o0;

    vecs[0] = '{"wr_pwr0", 7'h68, 1'b0, 8'h6B, 8'h00, '0, 0,
                8'h00, 8'h00, 1'b1, 8'h00};
    vecs[1] = '{"rd_who", 7'h68, 1'b1, 8'h75, 8'h00, '0, 1,
                8'h68, 8'h00, 1'b1, 8'h00};
    vecs[2] = '{"rd_ax", 7'h68, 1'b1, 8'h3B, 8'h00,
                {16'h1234, 80'h0}, 2, 8'h12,
                AUTOINC ? 8'h34 : 8'h12, 1'b1, 8'h00};
    vecs[3] = '{"bad_addr", 7'h69, 1'b0, 8'h6B, 8'h55, '0, 0,
                8'h00, 8'h00, 1'b0, 8'h00};
    vecs[4] = '{"wr_pwr1", 7'h68, 1'b0, 8'h6B, 8'h01, '0, 0,
                8'h00, 8'h00, 1'b1, 8'h01};
    vecs[5] = '{"rd_pwr", 7'h68, 1'b1, 8'h6B, 8'h00, '0, 1,
                8'h01, 8'h00, 1'b1, 8'h01};
    vecs[6] = '{"rd_gz", 7'h68, 1'b1, 8'h47, 8'h00,
                96'h1122_3344_5566_7788_99AA_ABCD, 2, 8'hAB,
                AUTOINC ? 8'hCD : 8'hAB, 1'b1, 8'h01};
    vecs[7] = '{"rd_temp", 7'h68, 1'b1, 8'h41, 8'h00,
                96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1, 8'h00,
                8'h00, 1'b1, 8'h01};
    vecs[8] = '{"wr_other", 7'h68, 1'b0, 8'h10, 8'h55, '0, 0,
                8'h00, 8'h00, 1'b1, 8'h01};
    vecs[9] = '{"rd_other", 7'h68, 1'b1, 8'h10, 8'h00,
                96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1, 8'h00,
                8'h00, 1'b1, 8'h01};

    repeat (4) @(posedge clk);
    #1;
    check("rst SDA_oe", SDA_oe, 0);
    check("rst PwrMgmt", PwrMgmt, 8'h40);
    check("rst WrStrobe", WrStrobe, 0);
    check("rst WrAddr", WrAddr, 0);
    check("rst BusBusy", BusBusy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int v = 0; v < NV; v++) begin
      SensorData = vecs[v].sensor;
      s0 = strobe_cnt;
      o0 = oe_cnt;
      i2c_start();
      write_byte({vecs[v].dev, 1'b0}, ack);
      check({vecs[v].name, " dev_ack"}, ack, vecs[v].exp_ack);
      if (!vecs[v].exp_ack) begin
        write_byte(vecs[v].reg_a, ack);
        check({vecs[v].name, " busy"}, BusBusy, 1);
        check({vecs[v].name, " oe_quiet"}, oe_cnt - o0, 0);
        i2c_stop();
      end else begin
        write_byte(vecs[v].reg_a, ack);
        check({vecs[v].name, " reg_ack"}, ack, 1);
        if (!vecs[v].rd) begin
          write_byte(vecs[v].wdata, ack);
          check({vecs[v].name, " data_ack"}, ack, 1);
          i2c_stop();
          check({vecs[v].name, " strobes"}, strobe_cnt - s0, 1);
          check({vecs[v].name, " WrAddr"}, WrAddr, vecs[v].reg_a);
        end else begin
          i2c_start();
          write_byte({vecs[v].dev, 1'b1}, ack);
          check({vecs[v].name, " rd_ack"}, ack, 1);
          for (int b = 0; b < vecs[v].nrd; b++) begin
            read_byte(b == vecs[v].nrd - 1, d0);
            check({vecs[v].name, " rd_byte"}, d0,
                  (b == 0) ? vecs[v].exp0 : vecs[v].exp1);
          end
          i2c_stop();
        end
      end
      check({vecs[v].name, " idle_busy"}, BusBusy, 0);
      check({vecs[v].name, " idle_oe"}, SDA_oe, 0);
      check({vecs[v].name, " PwrMgmt"}, PwrMgmt, vecs[v].exp_pwr);
    end

    // snapshot must hold across a burst even if sensors change
    SensorData = {16'h1234, 80'h0};
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h3B, ack);
    i2c_start();
    write_byte(8'hD1, ack);
    check("snap rd_ack", ack, 1);
    read_byte(1'b0, d0);
    SensorData = '1;
    read_byte(1'b1, d1);
    i2c_stop();
    check("snap byte0", d0, 8'h12);
    check("snap byte1", d1, AUTOINC ? 8'h34 : 8'h12);

    // reset while the target drives a 0 bit of WHO_AM_I
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h75, ack);
    i2c_start();
    write_byte(8'hD1, ack);
    check("mid_rst driving", SDA_oe, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst oe", SDA_oe, 0);
    check("mid_rst pwr", PwrMgmt, 8'h40);
    check("mid_rst busy", BusBusy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    i2c_stop();
    i2c_start();
    write_byte(8'hD0, ack);
    check("post_rst dev_ack", ack, 1);
    write_byte(8'h6B, ack);
    check("post_rst reg_ack", ack, 1);
    write_byte(8'h07, ack);
    check("post_rst data_ack", ack, 1);
    i2c_stop();
    check("post_rst pwr", PwrMgmt, 8'h07);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
